multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit that accepts `mul`/`div` operations issued from the DX stage, with operands already resolved by the ALU operand/bypass logic. It runs the operation over multiple cycles and asserts `busy` so the pipeline controller stalls FD/DX. It returns the result, exception flag and destination-register tag to the writeback path with a one-cycle ready pulse.

---
 rtl/multdiv_pkg.sv | 19 +
 rtl/multdiv_if.sv | 30 +++
 rtl/multdiv_iter.sv | 38 +++
 rtl/multdiv_unit.sv | 117 +++++++++++
 tb/tb_multdiv_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multdiv_pkg: shared state encoding and constants for the multiply/divide unit.
// Revision 1.0
// ----------------------------------------------------------------------------
package multdiv_pkg;

   localparam int          ITER    = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multdiv_if: issue/result bundle between the DX/writeback path and multdiv_unit.
// Revision 1.0
// ----------------------------------------------------------------------------
interface multdiv_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [4:0]       dst_tag;
   logic             busy;
   logic             data_resultRDY;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic [4:0]       result_tag;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dst_tag,
      input  busy, data_resultRDY, data_result, data_exception, result_tag
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dst_tag,
      output busy, data_resultRDY, data_result, data_exception, result_tag
   );
endinterface
`default_nettype wire

// File: rtl/multdiv_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multdiv_iter: one combinational shift-add (multiply) or restore-subtract
// (divide) step on the shared 2*WIDTH accumulator.  Revision 1.0
// ----------------------------------------------------------------------------
module multdiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 i_op_div,
   input  logic [2*WIDTH-1:0]   i_acc,
   input  logic [WIDTH-1:0]     i_operand,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic             w_fits;
   logic [WIDTH-1:0] w_sub;

   always_comb begin
      // Multiply: {upper, multiplier} -- add into upper on LSB, then shift right.
      w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
      // Divide: {remainder, dividend} -- shift left, trial-subtract the divisor.
      w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
      w_fits   = (w_rem_sh >= {1'b0, i_operand});
      w_sub    = w_rem_sh[WIDTH-1:0] - i_operand;
      o_acc    = {w_sum, i_acc[WIDTH-1:1]};
      if (i_op_div) begin
         if (w_fits) begin
            o_acc = {w_sub, i_acc[WIDTH-2:0], 1'b1};
         end else begin
            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multdiv_unit: iterative signed 32-bit multiply/divide with busy stall and
// one-cycle ready pulse toward writeback.  Revision 1.0
// ----------------------------------------------------------------------------
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic      clock,
   input  logic      reset_n,
   multdiv_if.slave  bus
);
   import multdiv_pkg::*;

   localparam int CW = $clog2(ITER);

   state_t             r_state;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_sign;
   logic [4:0]         r_tag;
   logic [CW-1:0]      r_cnt;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic               w_is_div;
   logic               w_last;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic               w_mul_exc;
   logic               w_div_exc;

   assign w_abs_a  = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
   assign w_abs_b  = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
   assign w_is_div = (r_state == ST_DIV);
   assign w_last   = (r_cnt == CW'(ITER - 1));

   multdiv_iter #(.WIDTH(WIDTH)) u_iter (
      .i_op_div  (w_is_div),
      .i_acc     (r_acc),
      .i_operand (r_opnd),
      .o_acc     (w_step)
   );

   // Final fix-up applied to the value the last step produces.
   assign w_prod    = r_sign ? (~w_step + 1'b1) : w_step;
   assign w_mul_exc = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
   assign w_quot    = r_sign ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
   // Only INT_MIN / -1 yields a positive quotient magnitude of 2^31.
   assign w_div_exc = !r_sign && (w_step[WIDTH-1:0] == INT_MIN);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state            <= ST_IDLE;
         r_acc              <= '0;
         r_opnd             <= '0;
         r_sign             <= 1'b0;
         r_tag              <= '0;
         r_cnt              <= '0;
         bus.busy           <= 1'b0;
         bus.data_resultRDY <= 1'b0;
         bus.data_result    <= '0;
         bus.data_exception <= 1'b0;
         bus.result_tag     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               bus.data_resultRDY <= 1'b0;
               if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                  r_sign   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                  r_tag    <= bus.dst_tag;
                  r_cnt    <= '0;
                  bus.busy <= 1'b1;
                  if (bus.ctrl_MULT) begin
                     r_state <= ST_MUL;
                     r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                     r_opnd  <= w_abs_a;
                  end else if (bus.data_operandB == '0) begin
                     r_state            <= ST_DONE;
                     bus.data_resultRDY <= 1'b1;
                     bus.data_result    <= '0;
                     bus.data_exception <= 1'b1;
                     bus.result_tag     <= bus.dst_tag;
                  end else begin
                     r_state <= ST_DIV;
                     r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                     r_opnd  <= w_abs_b;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state            <= ST_DONE;
                  bus.data_resultRDY <= 1'b1;
                  bus.data_result    <= w_is_div ? w_quot : w_prod[WIDTH-1:0];
                  bus.data_exception <= w_is_div ? w_div_exc : w_mul_exc;
                  bus.result_tag     <= r_tag;
               end
            end
            ST_DONE: begin
               r_state            <= ST_IDLE;
               bus.data_resultRDY <= 1'b0;
               bus.busy           <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multdiv_unit: directed and randomized checks of multdiv_unit against an
// arithmetic reference model.  Revision 1.0
// ----------------------------------------------------------------------------
module tb_multdiv_unit;

   logic clock;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   multdiv_if #(.WIDTH(32)) bus ();

   multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Reference: full-precision signed arithmetic, with the unit's fault rules.
   function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
      longint p;
      int     q;
      lat = 33;
      if (is_mul) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0; e = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000; e = 1'b1;
      end else begin
         q = $signed(a) / $signed(b);
         r = q; e = 1'b0;
      end
   endfunction

   // Issue one start, then watch the outputs cycle by cycle. kind 1 pulses a
   // divide-by-zero start at cycle inj; kind 2 asserts reset at cycle inj.
   task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int inj, input int kind,
                        output int lat, output int busy_cyc, output int rdy_cnt,
                        output logic [31:0] res, output logic exc, output logic [4:0] rtag,
                        output logic [39:0] post_rst);
      @(posedge clock); #1;
      bus.ctrl_MULT = m; bus.ctrl_DIV = d;
      bus.data_operandA = a; bus.data_operandB = b; bus.dst_tag = tag;
      @(posedge clock); #1;
      bus.ctrl_MULT = 1'b0;
      lat = -1; busy_cyc = 0; rdy_cnt = 0; res = '0; exc = 1'b0; rtag = '0; post_rst = '1;
      for (int c = 1; c <= 60; c++) begin
         if (bus.busy === 1'b1) busy_cyc++;
         if (bus.data_resultRDY === 1'b1) begin
            rdy_cnt++;
            if (lat < 0) begin
               lat = c; res = bus.data_result; exc = bus.data_exception; rtag = bus.result_tag;
            end
         end
         if (kind == 2 && c == inj + 1)
            post_rst = {bus.busy, bus.data_resultRDY, bus.data_exception, bus.result_tag, bus.data_result};
         bus.ctrl_DIV      = (kind == 1 && c == inj);
         bus.data_operandA = $urandom();
         bus.data_operandB = (kind == 1 && c == inj) ? 32'd0 : $urandom();
         bus.dst_tag       = 5'($urandom());
         reset_n           = !(kind == 2 && c == inj);
         if (kind != 2 && lat >= 0 && c >= lat + 3) break;
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      logic [39:0] obs;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      obs = {bus.busy, bus.data_resultRDY, bus.data_exception, bus.result_tag, bus.data_result};
      n_cmp++;
      if (obs !== 40'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_mul();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(1, 0, 32'd7, 32'hFFFF_FFFA, 5'd5, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
      n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
      n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL mul_rdy_count: got %0d want 1", rc); end
      n_cmp++;
      if ({r, e, t} !== {32'hFFFF_FFD6, 1'b0, 5'd5}) begin
         n_bad++; $display("FAIL mul_result: got %h/%b/%0d want ffffffd6/0/5", r, e, t);
      end
      n_cmp++;
      if ({bus.data_result, bus.data_exception, bus.result_tag} !== {32'hFFFF_FFD6, 1'b0, 5'd5}) begin
         n_bad++; $display("FAIL mul_hold: got %h/%b/%0d want ffffffd6/0/5",
                           bus.data_result, bus.data_exception, bus.result_tag);
      end
   endtask

   task automatic test_mul_overflow();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd9, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++;
      if ({r, e} !== {32'hFFFF_FFFE, 1'b1}) begin
         n_bad++; $display("FAIL mul_overflow: got %h/%b want fffffffe/1", r, e);
      end
   endtask

   task automatic test_div();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(0, 1, 32'hFFFF_FF9C, 32'd7, 5'd12, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", lat); end
      n_cmp++;
      if ({r, e, t} !== {32'hFFFF_FFF2, 1'b0, 5'd12}) begin
         n_bad++; $display("FAIL div_result: got %h/%b/%0d want fffffff2/0/12", r, e, t);
      end
      do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++;
      if ({r, e} !== {32'h8000_0000, 1'b1}) begin
         n_bad++; $display("FAIL div_intmin: got %h/%b want 80000000/1", r, e);
      end
   endtask

   task automatic test_div_zero();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(0, 1, 32'd5, 32'd0, 5'd30, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
      n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL div0_busy_cycles: got %0d want 1", bc); end
      n_cmp++;
      if ({r, e, t} !== {32'd0, 1'b1, 5'd30}) begin
         n_bad++; $display("FAIL div0_result: got %h/%b/%0d want 0/1/30", r, e, t);
      end
   endtask

   task automatic test_ignore_restart();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(1, 0, 32'd1234, 32'hFFFF_FF00, 5'd17, 10, 1, lat, bc, rc, r, e, t, pr);
      n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL restart_rdy_count: got %0d want 1", rc); end
      n_cmp++;
      if ({lat, r, e, t} !== {32'd33, 32'hFFFB_2E00, 1'b0, 5'd17}) begin
         n_bad++; $display("FAIL restart_result: got %0d/%h/%b/%0d want 33/fffb2e00/0/17", lat, r, e, t);
      end
   endtask

   task automatic test_simultaneous();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(1, 1, 32'd3, 32'd4, 5'd2, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++;
      if ({lat, r, e} !== {32'd33, 32'd12, 1'b0}) begin
         n_bad++; $display("FAIL simultaneous: got %0d/%h/%b want 33/0000000c/0", lat, r, e);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc, rc; logic [31:0] r; logic e; logic [4:0] t; logic [39:0] pr;
      do_op(1, 0, 32'd123, 32'd456, 5'd21, 15, 2, lat, bc, rc, r, e, t, pr);
      n_cmp++; if (pr !== 40'd0) begin n_bad++; $display("FAIL midreset_outputs: got %h want 0", pr); end
      n_cmp++; if (rc !== 0) begin n_bad++; $display("FAIL midreset_rdy_count: got %0d want 0", rc); end
      do_op(1, 0, 32'd2, 32'd3, 5'd4, 0, 0, lat, bc, rc, r, e, t, pr);
      n_cmp++;
      if ({lat, r, e, t} !== {32'd33, 32'd6, 1'b0, 5'd4}) begin
         n_bad++; $display("FAIL midreset_fresh: got %0d/%h/%b/%0d want 33/6/0/4", lat, r, e, t);
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      int lat;
      seen = 1'b0;
      @(posedge clock); #1;
      bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'hFFFF_FFF7; bus.data_operandB = 32'd11; bus.dst_tag = 5'd3;
      @(posedge clock); #1;
      bus.ctrl_MULT = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         if (bus.data_resultRDY === 1'b1) seen = 1'b1;
         else begin @(posedge clock); #1; end
      end
      n_cmp++;
      if ({seen, bus.data_result} !== {1'b1, 32'hFFFF_FF9D}) begin
         n_bad++; $display("FAIL b2b_first: got %b/%h want 1/ffffff9d", seen, bus.data_result);
      end
      // A start during DONE must be dropped.
      bus.ctrl_DIV = 1'b1; bus.data_operandB = 32'd0;
      @(posedge clock); #1;
      n_cmp++;
      if ({bus.busy, bus.data_resultRDY} !== 2'b00) begin
         n_bad++; $display("FAIL b2b_done_start: got busy/rdy %b%b want 00", bus.busy, bus.data_resultRDY);
      end
      bus.data_operandA = 32'd1000; bus.data_operandB = 32'hFFFF_FFF9; bus.dst_tag = 5'd9;
      @(posedge clock); #1;
      bus.ctrl_DIV = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         if (bus.data_resultRDY === 1'b1) lat = c;
         else begin @(posedge clock); #1; end
      end
      n_cmp++;
      if ({lat, bus.data_result, bus.result_tag} !== {32'd33, 32'hFFFF_FF72, 5'd9}) begin
         n_bad++; $display("FAIL b2b_second: got %0d/%h/%0d want 33/ffffff72/9", lat, bus.data_result, bus.result_tag);
      end
   endtask

   task automatic test_random();
      logic [31:0] special [5];
      int lat, bc, rc, kind, elat; logic [31:0] a, b, r, er; logic e, ee; logic [4:0] t, tag; logic [39:0] pr;
      special[0] = 32'd0; special[1] = 32'd1; special[2] = 32'hFFFF_FFFF;
      special[3] = 32'h8000_0000; special[4] = 32'h7FFF_FFFF;
      for (int i = 0; i < 30; i++) begin
         kind = $urandom_range(0, 5);
         a   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom();
         b   = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom();
         if (kind >= 3 && b == 32'd0) b = 32'd3;
         if (kind == 5) b = 32'd0;
         if (kind == 1) b = b >> $urandom_range(0, 31);
         tag = 5'($urandom());
         model(kind < 3, a, b, er, ee, elat);
         do_op(kind < 3, kind >= 3, a, b, tag, 0, 0, lat, bc, rc, r, e, t, pr);
         n_cmp++;
         if ({r, e, t} !== {er, ee, tag}) begin
            n_bad++; $display("FAIL rand_%0d_result: op %0d a=%h b=%h got %h/%b/%0d want %h/%b/%0d",
                              i, kind, a, b, r, e, t, er, ee, tag);
         end
         n_cmp++;
         if (lat !== elat) begin
            n_bad++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, elat);
         end
      end
   endtask

   initial begin
      clock = 1'b0;
      reset_n = 1'b0;
      bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
      bus.data_operandA = '0; bus.data_operandB = '0; bus.dst_tag = '0;
      test_reset();
      test_mul();
      test_mul_overflow();
      test_div();
      test_div_zero();
      test_ignore_restart();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
